demux_rr_scheduler: RTL and testbench
=====================================

DEMUX_RR_SCHEDULER -- requirements
Module: demux_rr_scheduler

Interface
REQ-001 The block SHALL have parameter HOLD_W, default 4, giving the width of hold_len and the internal hold counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 8, per-channel route requests; bit k means requester k wants the 1:8 demux output k.
REQ-005 The block SHALL have port hold_len, input, HOLD_W, maximum route window minus one, in cycles.
REQ-006 The block SHALL have port en, output, 1, demux enable.
REQ-007 The block SHALL have ports s2, s1, s0, output, 1 each, demux select with {s2,s1,s0} equal to the granted channel index.
REQ-008 The block SHALL have port grant, output, 8, one-hot grant to the channel being routed; all zero otherwise.
REQ-009 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 The block SHALL have port done, output, 1, one-cycle pulse marking the end of a route window.

Function
REQ-011 The block SHALL implement FSM states IDLE, SETUP, ROUTE, GUARD; all outputs decoded from registered state only (Moore).
REQ-012 In IDLE with req equal to 0, the block SHALL remain in IDLE.
REQ-013 In IDLE with req nonzero, the block SHALL choose the first set req bit searching upward from ptr and wrapping 7->0, latch that index into sel, load cnt with hold_len, and move to SETUP.
REQ-014 In SETUP, the block SHALL drive {s2,s1,s0}=sel, en=0, grant=0 for exactly one cycle (break-before-make), then move to ROUTE.
REQ-015 In ROUTE, the block SHALL drive en=1, {s2,s1,s0}=sel, grant=1<<sel.
REQ-016 In ROUTE, if cnt==0 or req[sel]==0, the block SHALL move to GUARD; otherwise it SHALL decrement cnt and stay in ROUTE.
REQ-017 ROUTE SHALL last at most hold_len+1 cycles and at least 1 cycle.
REQ-018 In GUARD, the block SHALL drive en=0, grant=0, {s2,s1,s0}=sel, done=1 for one cycle, set ptr=(sel+1) mod 8, then move to IDLE.
REQ-019 done SHALL be 0 in every state other than GUARD.
REQ-020 Select lines SHALL change only on entry to SETUP; they SHALL hold sel through ROUTE, GUARD and the following IDLE.
REQ-021 Changes to hold_len outside IDLE SHALL NOT affect the current window.
REQ-022 Changes to req bits other than req[sel] during SETUP/ROUTE/GUARD SHALL NOT affect the current window.
REQ-023 Latency: if req is sampled nonzero in IDLE at edge N, en SHALL be high from edge N+2.
REQ-024 Minimum spacing between two ROUTE windows SHALL be 3 cycles (GUARD, IDLE, SETUP).
REQ-025 The block SHALL keep the single-channel case fair: if req[k] alone stays high, it SHALL be re-granted after every GUARD.

Reset
REQ-026 While rst_n=0, the block SHALL force state=IDLE, ptr=0, sel=0, cnt=0, en=0, s2=s1=s0=0, grant=0, busy=0, done=0, immediately and independent of clk.
REQ-027 If reset is asserted mid-ROUTE, en SHALL drop asynchronously; after release the block SHALL resume in IDLE with ptr=0 and no done pulse.

Verification
REQ-028 The bench SHALL cover this case: reset, then req=8'h10, hold_len=3. Required: SETUP with sel=4, then en=1 and grant=8'h10 for 4 cycles, then done=1 for 1 cycle with ptr=5.
REQ-029 The bench SHALL cover this case: req=8'hFF held, hold_len=0. Required: grants in order 0,1,...,7,0, each with en high for 1 cycle, windows 4 cycles apart.
REQ-030 The bench SHALL cover this case: after a grant to channel 6 (ptr=7), req=8'h41. Required: next grant is channel 0, then channel 6 (wrap-around search).
REQ-031 The bench SHALL cover this case: hold_len=9, and req[sel] dropped in the 3rd ROUTE cycle. Required: en is high for exactly 3 cycles, then GUARD with done=1.
REQ-032 The bench SHALL cover this case: rst_n pulsed low mid-ROUTE. Required: en=0 and grant=0 asynchronously, no done, and the first grant after release searches from channel 0.
REQ-033 In all tests, the bench SHALL check that en=1 only when grant is one-hot with index equal to {s2,s1,s0}.

Source files
------------

// File: rtl/demux_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : demux_rr_scheduler
//  Description : Round-robin scheduler driving a 1:8 demultiplexer. A request
//                is picked with a rotating-priority search starting at the
//                round-robin pointer. The select lines are set up one cycle
//                before the enable (break-before-make). The route is held for
//                at most hold_len+1 cycles, or until the requester lets go.
//                A guard cycle with a done pulse closes each window.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_rr_scheduler #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        req,
    input  logic [HOLD_W-1:0] hold_len,
    output logic              en,
    output logic              s2,
    output logic              s1,
    output logic              s0,
    output logic [7:0]        grant,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_ROUTE = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    localparam logic [2:0] c_SEL_STEP = 3'd1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_ptr;
    logic [2:0]        w_ptr_nxt;
    logic [2:0]        r_sel;
    logic [2:0]        w_sel_nxt;
    logic [HOLD_W-1:0] r_cnt;
    logic [HOLD_W-1:0] w_cnt_nxt;

    // Rotated view of the requests so that bit 0 corresponds to the channel
    // at r_ptr; the lowest set bit of this view is the round-robin winner.
    logic [15:0]       w_req_dbl;
    logic [7:0]        w_req_rot;
    logic [2:0]        w_pick_off;
    logic [2:0]        w_pick;
    logic              w_req_any;
    logic              w_route_end;

    assign w_req_dbl = {req, req};
    assign w_req_rot = w_req_dbl[r_ptr +: 8];
    assign w_req_any = |req;

    // Lowest-set-bit priority encoder over the rotated request vector
    always_comb begin
        w_pick_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_pick_off = 3'(i);
            end
        end
    end

    // Undo the rotation; 3-bit addition wraps 7 -> 0 naturally
    assign w_pick = r_ptr + w_pick_off;

    // The window closes when the budget is spent or the owner withdraws
    assign w_route_end = (r_cnt == '0) || !req[r_sel];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 3'd0;
            r_sel   <= 3'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; sel and cnt are only loaded on the IDLE->SETUP step
    // so later changes of hold_len or other req bits cannot disturb a window
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_sel_nxt   = w_pick;
                    w_cnt_nxt   = hold_len;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ROUTE;
            end
            ST_ROUTE: begin
                if (w_route_end) begin
                    w_state_nxt = ST_GUARD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_GUARD: begin
                w_ptr_nxt   = r_sel + c_SEL_STEP;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Moore output decode from registered state and select only
    always_comb begin
        en    = 1'b0;
        grant = 8'h00;
        busy  = 1'b0;
        done  = 1'b0;
        s2    = r_sel[2];
        s1    = r_sel[1];
        s0    = r_sel[0];
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_SETUP: begin
                busy = 1'b1;
            end
            ST_ROUTE: begin
                busy  = 1'b1;
                en    = 1'b1;
                grant = 8'd1 << r_sel;
            end
            ST_GUARD: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_rr_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_demux_rr_scheduler
//  Description : Self-checking bench for demux_rr_scheduler: vector table,
//                directed corner sequences and a randomized run against a
//                window-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_rr_scheduler;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [3:0] hold_len;
    logic       en;
    logic       s2;
    logic       s1;
    logic       s0;
    logic [7:0] grant;
    logic       busy;
    logic       done;

    int total;
    int bad;

    demux_rr_scheduler #(.HOLD_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .hold_len (hold_len),
        .en       (en),
        .s2       (s2),
        .s1       (s1),
        .s0       (s0),
        .grant    (grant),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [3:0] hold;
        logic       en;
        logic [7:0] grant;
        logic [2:0] sel;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[11];

    // window-level reference model
    int m_win;
    int m_age;
    int m_limit;
    int m_closing;
    int m_ch;
    int m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    function automatic int onehot_idx(input logic [7:0] v);
        int r;
        r = -1;
        for (int i = 7; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // enable may only be high with a one-hot grant matching the select lines
    task automatic inv_check();
        logic [7:0] want;
        if (en) begin
            want = 8'd1 << {s2, s1, s0};
            chk("en_grant_sel", {24'd0, grant}, {24'd0, want});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        inv_check();
    endtask

    task automatic model_reset();
        m_win     = 0;
        m_age     = 0;
        m_limit   = 0;
        m_closing = 0;
        m_ch      = 0;
        m_ptr     = 0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = 8'h00;
        hold_len = 4'd0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock of the model: a window is a setup cycle, up to hold_len+1
    // route cycles, then one guard cycle after which the pointer advances.
    task automatic model_step();
        int found;
        if (m_win == 0) begin
            if (req != 8'h00) begin
                found = 0;
                for (int i = 0; i < 8; i++) begin
                    if (found == 0 && req[(m_ptr + i) % 8]) begin
                        m_ch  = (m_ptr + i) % 8;
                        found = 1;
                    end
                end
                m_win     = 1;
                m_age     = 0;
                m_limit   = int'(hold_len) + 1;
                m_closing = 0;
            end
        end else if (m_closing != 0) begin
            m_win = 0;
            m_ptr = (m_ch + 1) % 8;
        end else begin
            if (m_age >= 1 && (m_age == m_limit || !req[m_ch])) m_closing = 1;
            m_age++;
        end
    endtask

    task automatic model_compare();
        logic       e_en;
        logic [7:0] e_grant;
        e_en    = (m_win != 0) && (m_age >= 1) && (m_closing == 0);
        e_grant = e_en ? (8'd1 << m_ch) : 8'h00;
        chk("rnd_en",    {31'd0, en}, {31'd0, e_en});
        chk("rnd_grant", {24'd0, grant}, {24'd0, e_grant});
        chk("rnd_sel",   {29'd0, s2, s1, s0}, 32'(m_ch));
        chk("rnd_busy",  {31'd0, busy}, 32'(m_win != 0));
        chk("rnd_done",  {31'd0, done}, 32'((m_win != 0) && (m_closing != 0)));
    endtask

    // wait for a route window, report its channel, then wait for it to end
    task automatic wait_grant(input string name, output int ch);
        int k;
        ch = -1;
        for (k = 0; k < 40 && !en; k++) tick();
        if (!en) begin
            timeout(name);
        end else begin
            ch = onehot_idx(grant);
            for (k = 0; k < 40 && en; k++) tick();
            if (en) timeout(name);
        end
    endtask

    initial begin
        int ch;
        int nwin;
        int chs[9];
        int cyc[9];
        int k;
        int r;

        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        req      = 8'h00;
        hold_len = 4'd0;
        model_reset();

        // ---------------- reset state ----------------
        #12;
        chk("rst_en",    {31'd0, en}, 32'd0);
        chk("rst_grant", {24'd0, grant}, 32'd0);
        chk("rst_sel",   {29'd0, s2, s1, s0}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);

        // ---------------- vector table: single channel 4, hold 3 ----------
        tbl[0]  = '{8'h10, 4'd3, 1'b0, 8'h00, 3'd4, 1'b1, 1'b0};
        tbl[1]  = '{8'h10, 4'd3, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0};
        tbl[2]  = '{8'h10, 4'd3, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0};
        tbl[3]  = '{8'h10, 4'd3, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0};
        tbl[4]  = '{8'h10, 4'd3, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0};
        tbl[5]  = '{8'h10, 4'd3, 1'b0, 8'h00, 3'd4, 1'b1, 1'b1};
        tbl[6]  = '{8'h00, 4'd3, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0};
        // pointer now 5: with channels 4 and 5 asking, 5 must win
        tbl[7]  = '{8'h30, 4'd0, 1'b0, 8'h00, 3'd5, 1'b1, 1'b0};
        tbl[8]  = '{8'h30, 4'd0, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0};
        tbl[9]  = '{8'h30, 4'd0, 1'b0, 8'h00, 3'd5, 1'b1, 1'b1};
        tbl[10] = '{8'h00, 4'd0, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            req      = tbl[i].req;
            hold_len = tbl[i].hold;
            tick();
            chk($sformatf("tbl%0d_en", i),    {31'd0, en}, {31'd0, tbl[i].en});
            chk($sformatf("tbl%0d_grant", i), {24'd0, grant}, {24'd0, tbl[i].grant});
            chk($sformatf("tbl%0d_sel", i),   {29'd0, s2, s1, s0}, {29'd0, tbl[i].sel});
            chk($sformatf("tbl%0d_busy", i),  {31'd0, busy}, {31'd0, tbl[i].busy});
            chk($sformatf("tbl%0d_done", i),  {31'd0, done}, {31'd0, tbl[i].done});
        end

        // ---------------- all requesting, hold 0: 0..7,0 every 4 cycles ---
        do_reset();
        req      = 8'hFF;
        hold_len = 4'd0;
        nwin     = 0;
        for (k = 0; k < 60 && nwin < 9; k++) begin
            tick();
            if (en) begin
                chs[nwin] = onehot_idx(grant);
                cyc[nwin] = k;
                nwin++;
            end
        end
        if (nwin < 9) begin
            timeout("ff_windows");
        end else begin
            for (int i = 0; i < 9; i++) begin
                chk($sformatf("ff_order%0d", i), 32'(chs[i]), 32'(i % 8));
                if (i > 0) chk($sformatf("ff_gap%0d", i), 32'(cyc[i] - cyc[i-1]), 32'd4);
            end
        end

        // ---------------- wrap-around search from pointer 7 ---------------
        do_reset();
        req      = 8'h40;
        hold_len = 4'd0;
        wait_grant("wrap_first", ch);
        chk("wrap_first_ch", 32'(ch), 32'd6);
        chk("wrap_guard_done", {31'd0, done}, 32'd1);
        req = 8'h41;
        wait_grant("wrap_second", ch);
        chk("wrap_second_ch", 32'(ch), 32'd0);
        wait_grant("wrap_third", ch);
        chk("wrap_third_ch", 32'(ch), 32'd6);

        // ---------------- early release in the 3rd route cycle -------------
        do_reset();
        req      = 8'h04;
        hold_len = 4'd9;
        for (k = 0; k < 20 && !en; k++) tick();
        if (!en) begin
            timeout("drop_start");
        end else begin
            tick();
            chk("drop_en_c2", {31'd0, en}, 32'd1);
            tick();
            chk("drop_en_c3", {31'd0, en}, 32'd1);
            req = 8'h00;
            tick();
            chk("drop_en_after", {31'd0, en}, 32'd0);
            chk("drop_done",     {31'd0, done}, 32'd1);
            tick();
            chk("drop_idle_busy", {31'd0, busy}, 32'd0);
        end

        // ---------------- asynchronous reset mid-route ---------------------
        do_reset();
        req      = 8'h04;
        hold_len = 4'd0;
        wait_grant("ar_pre", ch);
        chk("ar_pre_ch", 32'(ch), 32'd2);
        req      = 8'h20;
        hold_len = 4'd9;
        for (k = 0; k < 20 && !en; k++) tick();
        if (!en) begin
            timeout("ar_route");
        end else begin
            tick();
            #2;
            rst_n = 1'b0;
            #1;
            chk("ar_en",    {31'd0, en}, 32'd0);
            chk("ar_grant", {24'd0, grant}, 32'd0);
            chk("ar_busy",  {31'd0, busy}, 32'd0);
            chk("ar_done",  {31'd0, done}, 32'd0);
            @(posedge clk);
            #1;
            req      = 8'h21;
            hold_len = 4'd0;
            rst_n    = 1'b1;
            for (k = 0; k < 10 && !en; k++) begin
                tick();
                chk("ar_no_done", {31'd0, done}, 32'd0);
            end
            if (!en) timeout("ar_regrant");
            else chk("ar_regrant_ch", 32'(onehot_idx(grant)), 32'd0);
        end

        // ---------------- randomized run against the model -----------------
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 15));
            case (r)
                0: req = 8'h00;
                1: req = 8'd1 << $urandom_range(0, 7);
                2: req = 8'($urandom);
                3: req = 8'($urandom & $urandom);
                default: req = req;
            endcase
            if ($urandom_range(0, 7) == 0) hold_len = 4'($urandom_range(0, 6));
            @(posedge clk);
            model_step();
            #1;
            inv_check();
            model_compare();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
